// File: rtl/bist_controller.sv
// BIST sequencer for the full-adder self-test path: clears LFSR/MISR, runs PATTERN_COUNT patterns, checks the signature.
// Optional BIST_AUTO_START_EN: the first edge after reset release behaves as a start request (power-on self-test).
module bist_controller #(
  parameter int                   PATTERN_COUNT = 7,
  parameter int                   SIG_WIDTH     = 4,
  parameter logic [SIG_WIDTH-1:0] GOLDEN        = 4'b0011
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 lfsr_finish,
  input  logic [SIG_WIDTH-1:0] misr_sig,
  output logic                 testmode,
  output logic                 gen_clear,
  output logic                 gen_en,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fault_detected,
  output logic                 seq_error,
  output logic [7:0]           pattern_cnt,
  output logic [2:0]           state_dbg
);

  // Handshake: start is a level request sampled only in IDLE; busy is high from the
  // accepting edge until the run ends; done is a one-cycle pulse, raised as busy falls,
  // that qualifies pass/fault_detected. An aborted run never raises done.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    RUN     = 3'd2,
    FLUSH   = 3'd3,
    COMPARE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_CNT = 8'(PATTERN_COUNT - 1);
  localparam logic [7:0] MAX_CNT  = 8'(PATTERN_COUNT);

  state_t state, state_next;
  logic   start_eff;

`ifdef BIST_AUTO_START_EN
  logic auto_pending;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) auto_pending <= 1'b1;
    else        auto_pending <= 1'b0;
  end

  assign start_eff = start | auto_pending;
`else
  assign start_eff = start;
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    testmode   = 1'b0;
    gen_clear  = 1'b0;
    gen_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start_eff) state_next = CLEAR;
      end
      CLEAR: begin
        testmode   = 1'b1;
        gen_clear  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        testmode = 1'b1;
        gen_en   = 1'b1;
        if (pattern_cnt == LAST_CNT) state_next = FLUSH;
      end
      FLUSH: begin
        // one extra enable so the MISR absorbs the response to the last pattern
        testmode   = 1'b1;
        gen_en     = 1'b1;
        state_next = COMPARE;
      end
      COMPARE: begin
        testmode   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (abort && state != IDLE) state_next = IDLE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done           <= 1'b0;
      pass           <= 1'b0;
      fault_detected <= 1'b0;
      seq_error      <= 1'b0;
      pattern_cnt    <= 8'd0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        pass           <= 1'b0;
        fault_detected <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_eff) begin
              pass           <= 1'b0;
              fault_detected <= 1'b0;
              seq_error      <= 1'b0;
            end
          end
          CLEAR: pattern_cnt <= 8'd0;
          RUN: begin
            if (pattern_cnt != MAX_CNT) pattern_cnt <= pattern_cnt + 8'd1;
            // finish must coincide exactly with the last pattern
            if ((pattern_cnt == LAST_CNT) != lfsr_finish) seq_error <= 1'b1;
          end
          COMPARE: begin
            pass           <= (misr_sig == GOLDEN) && !seq_error;
            fault_detected <= !((misr_sig == GOLDEN) && !seq_error);
            done           <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: directed plan cases plus randomized runs against a result model.
// Also exercises the power-on run when BIST_AUTO_START_EN is defined.
`timescale 1ns/1ps
module tb_bist_controller;

  localparam int         N    = 7;
  localparam logic [3:0] GOLD = 4'b0011;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       lfsr_finish = 1'b0;
  logic [3:0] misr_sig = 4'd0;
  logic       testmode, gen_clear, gen_en, busy, done, pass, fault_detected, seq_error;
  logic [7:0] pattern_cnt;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] exp_q[$];
  logic       last_pass_exp  = 1'b0;
  logic       last_fault_exp = 1'b0;
  logic [N-1:0] good_mask;

  bist_controller #(.PATTERN_COUNT(N), .SIG_WIDTH(4), .GOLDEN(GOLD)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .lfsr_finish(lfsr_finish), .misr_sig(misr_sig),
    .testmode(testmode), .gen_clear(gen_clear), .gen_en(gen_en),
    .busy(busy), .done(done), .pass(pass), .fault_detected(fault_detected),
    .seq_error(seq_error), .pattern_cnt(pattern_cnt), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Result of a completed run from the rules alone: finish must appear only on the last pattern.
  function automatic logic [2:0] model(input logic [N-1:0] mask, input logic [3:0] sig);
    logic [N-1:0] want;
    logic         serr, ok;
    want    = '0;
    want[N-1] = 1'b1;
    serr    = (mask != want);
    ok      = (sig == GOLD) && !serr;
    return {serr, !ok, ok};
  endfunction

  // driver: one run. Stage k = edges after the accepting edge (RUN 1..N, FLUSH N+1, COMPARE N+2).
  task automatic do_run(input logic [N-1:0] mask, input logic [3:0] sig, input int abort_stage,
                        input int rst_stage, input bit assert_start, input bit keep_start,
                        input bit in_clear);
    logic [2:0] e;
    if (!in_clear) begin
      if (assert_start) start = 1'b1;
      @(posedge clock); #1;
    end
    if (!keep_start) start = 1'b0;
    check_eq("clear_busy", busy, 1);
    check_eq("clear_gen_clear", gen_clear, 1);
    check_eq("clear_testmode", testmode, 1);
    check_eq("clear_gen_en", gen_en, 0);
    check_eq("clear_result_cleared", {pass, fault_detected, seq_error}, 0);
    if (abort_stage < 0 && rst_stage < 0) exp_q.push_back(model(mask, sig));
    for (int k = 1; k <= N + 2; k++) begin
      @(posedge clock); #1;
      check_eq($sformatf("busy_k%0d", k), busy, 1);
      check_eq($sformatf("testmode_k%0d", k), testmode, 1);
      check_eq($sformatf("gen_en_k%0d", k), gen_en, (k <= N + 1) ? 1 : 0);
      check_eq($sformatf("gen_clear_k%0d", k), gen_clear, 0);
      check_eq($sformatf("done_k%0d", k), done, 0);
      check_eq($sformatf("cnt_k%0d", k), pattern_cnt, (k <= N) ? k - 1 : N);
      if (k == rst_stage) begin
        #2 reset = 1'b0;
        #1;
        check_eq("async_reset_outputs",
                 {testmode, gen_clear, gen_en, busy, done, pass, fault_detected, seq_error, pattern_cnt}, 0);
        lfsr_finish = 1'b0;
        return;
      end
      if (k <= N) lfsr_finish = mask[k-1];
      else        lfsr_finish = 1'b0;
      misr_sig = (k == N + 2) ? sig : 4'($urandom);
      abort    = (k == abort_stage);
      if (abort) begin
        @(posedge clock); #1;
        abort       = 1'b0;
        lfsr_finish = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_pass", pass, 0);
        check_eq("abort_fault", fault_detected, 0);
        check_eq("abort_testmode", testmode, 0);
        last_pass_exp  = 1'b0;
        last_fault_exp = 1'b0;
        return;
      end
    end
    @(posedge clock); #1;
    lfsr_finish = 1'b0;
    check_eq("done_pulse", done, 1);
    check_eq("done_busy_low", busy, 0);
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("pass", pass, e[0]);
      check_eq("fault_detected", fault_detected, e[1]);
      check_eq("seq_error", seq_error, e[2]);
      last_pass_exp  = e[0];
      last_fault_exp = e[1];
    end
    @(posedge clock); #1;
    check_eq("done_falls", done, 0);
    if (keep_start) begin
      check_eq("restart_busy", busy, 1);
      check_eq("restart_pass_cleared", {pass, fault_detected}, 0);
      last_pass_exp  = 1'b0;
      last_fault_exp = 1'b0;
    end else begin
      check_eq("idle_busy", busy, 0);
      check_eq("hold_result", {pass, fault_detected}, {last_pass_exp, last_fault_exp});
    end
  endtask

  task automatic release_reset();
    @(posedge clock); #1;
    reset          = 1'b1;
    last_pass_exp  = 1'b0;
    last_fault_exp = 1'b0;
`ifdef BIST_AUTO_START_EN
    do_run(good_mask, GOLD, -1, -1, 1'b0, 1'b0, 1'b0);
`else
    @(posedge clock); #1;
    check_eq("no_auto_start", busy, 0);
`endif
  endtask

  initial begin
    logic [N-1:0] m;
    logic [3:0]   s;
    int           ab;
    good_mask      = '0;
    good_mask[N-1] = 1'b1;

    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_outputs",
             {testmode, gen_clear, gen_en, busy, done, pass, fault_detected, seq_error, pattern_cnt}, 0);
    release_reset();

    // fault-free run, then count holds in IDLE
    do_run(good_mask, GOLD, -1, -1, 1'b1, 1'b0, 1'b0);
    check_eq("cnt_hold_idle", pattern_cnt, N);
    // faulty signature
    do_run(good_mask, 4'b0101, -1, -1, 1'b1, 1'b0, 1'b0);
    // early finish in the 3rd RUN cycle
    m = '0; m[2] = 1'b1;
    do_run(m, GOLD, -1, -1, 1'b1, 1'b0, 1'b0);
    // abort in the 4th RUN cycle, then a normal run
    do_run(good_mask, GOLD, 4, -1, 1'b1, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clock); #1;
      check_eq("no_done_after_abort", done, 0);
    end
    do_run(good_mask, GOLD, -1, -1, 1'b1, 1'b0, 1'b0);
    // abort coincident with the COMPARE exit
    do_run(good_mask, GOLD, N + 2, -1, 1'b1, 1'b0, 1'b0);
    // start held high: one run, then a second begins right after done
    do_run(good_mask, GOLD, -1, -1, 1'b1, 1'b1, 1'b0);
    do_run(good_mask, 4'b1111, -1, -1, 1'b0, 1'b0, 1'b1);
    // asynchronous reset in FLUSH
    do_run(good_mask, GOLD, -1, N + 1, 1'b1, 1'b0, 1'b0);
    release_reset();

    // randomized runs
    repeat (24) begin
      m  = ($urandom_range(0, 1) == 0) ? good_mask : N'($urandom);
      s  = ($urandom_range(0, 1) == 0) ? GOLD : 4'($urandom_range(0, 15));
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, N + 2)) : -1;
      do_run(m, s, ab, -1, 1'b1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock); #1;
        check_eq("gap_busy", busy, 0);
        check_eq("gap_pass_hold", pass, last_pass_exp);
      end
    end

    if (exp_q.size() != 0) check_eq("sb_leftover", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
